// File: rtl/keypad_pkg.sv
// Shared types and constants for the keypad scan controller and its helpers.
package keypad_pkg;

   typedef enum logic [1:0] {
      SCAN     = 2'd0,
      DEBOUNCE = 2'd1,
      HELD     = 2'd2,
      RELEASE  = 2'd3
   } kp_state_e;

   // Idle row pattern: no row pulled low.
   localparam logic [31:0] KEY_NONE = 32'hFFFF_FFFF;

   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

   function automatic int unsigned code_width(input int unsigned rows, input int unsigned cols);
      return idx_width(rows * cols);
   endfunction

endpackage

// File: rtl/mod_sync2.sv
// Parameterized-width two-flop synchronizer with configurable reset value.
module mod_sync2 #(
   parameter int unsigned     W       = 1,
   parameter logic [W-1:0]    RST_VAL = '0
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [W-1:0]  i_d,
   output logic [W-1:0]  o_q
);

   logic [W-1:0] r_meta;
   logic [W-1:0] r_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_meta <= RST_VAL;
         r_q    <= RST_VAL;
      end else begin
         r_meta <= i_d;
         r_q    <= r_meta;
      end
   end

   assign o_q = r_q;

endmodule

// File: rtl/mod_keypad_scan_ctrl.sv
// Matrix keypad scanner: one shared debounce datapath, single-entry key event register.
// Optional auto-repeat while held is enabled by defining KEYPAD_AUTOREPEAT_EN.
module mod_keypad_scan_ctrl
   import keypad_pkg::*;
#(
   parameter int unsigned ROWS       = 4,
   parameter int unsigned COLS       = 4,
   parameter int unsigned SETTLE_CYC = 8,
   parameter int unsigned DB_N       = 15,
   parameter int unsigned REPEAT_DLY = 2**22,
   parameter int unsigned REPEAT_PER = 2**20
) (
   input  logic                                clk,
   input  logic                                rst,
   output logic [COLS-1:0]                     col_o,
   input  logic [ROWS-1:0]                     row_i,
   output logic [code_width(ROWS, COLS)-1:0]   key_code,
   output logic                                key_valid,
   input  logic                                key_ready,
   output logic                                key_held,
   output logic                                overrun
);

   localparam int unsigned CODE_W = code_width(ROWS, COLS);
   localparam int unsigned ROW_W  = idx_width(ROWS);
   localparam int unsigned COL_W  = idx_width(COLS);
   localparam int unsigned SET_W  = idx_width(SETTLE_CYC);

   if (SETTLE_CYC < 3 || REPEAT_DLY == 0 || REPEAT_PER == 0) begin : g_bad_cfg
      $error("mod_keypad_scan_ctrl: invalid parameter set");
   end

   kp_state_e          r_state, w_state_nxt;
   logic [ROWS-1:0]    w_rs;
   logic [SET_W-1:0]   r_settle;
   logic [DB_N-1:0]    r_db;
   logic [COL_W-1:0]   r_col, w_col_nxt;
   logic [COLS-1:0]    r_col_o;
   logic [ROW_W-1:0]   r_row, w_row_idx;
   logic [ROWS-1:0]    r_pat;
   logic [CODE_W-1:0]  r_code, w_code;
   logic               r_valid, r_held, r_ovr;
   logic               w_rs_idle, w_one_low, w_settle_done, w_db_full;
   logic               w_settle_clr, w_settle_inc, w_db_clr, w_db_inc;
   logic               w_capture, w_col_adv, w_emit, w_held_set, w_held_clr;
`ifdef KEYPAD_AUTOREPEAT_EN
   localparam int unsigned REP_W = idx_width((REPEAT_DLY > REPEAT_PER) ? REPEAT_DLY : REPEAT_PER);
   logic [REP_W-1:0]   r_rep;
   logic               r_rep_first, w_rep_hit;
`endif

   mod_sync2 #(.W(ROWS), .RST_VAL({ROWS{1'b1}})) u_row_sync (
      .clk   (clk),
      .rst_n (rst),
      .i_d   (row_i),
      .o_q   (w_rs)
   );

   assign w_rs_idle     = (w_rs == ROWS'(KEY_NONE));
   assign w_one_low     = $onehot(~w_rs);
   assign w_settle_done = (r_settle == SET_W'(SETTLE_CYC - 1));
   assign w_db_full     = &r_db;
   assign w_col_nxt     = (r_col == COL_W'(COLS - 1)) ? '0 : r_col + COL_W'(1);
   assign w_code        = CODE_W'(int'(r_row) * COLS + int'(r_col));

   // Index of the single low row; only meaningful when w_one_low is set.
   always_comb begin
      w_row_idx = '0;
      for (int i = 0; i < ROWS; i++) begin
         if (!w_rs[i]) w_row_idx = ROW_W'(i);
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_state <= SCAN;
      else      r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt  = r_state;
      w_settle_clr = 1'b0;
      w_settle_inc = 1'b0;
      w_db_clr     = 1'b0;
      w_db_inc     = 1'b0;
      w_capture    = 1'b0;
      w_col_adv    = 1'b0;
      w_emit       = 1'b0;
      w_held_set   = 1'b0;
      w_held_clr   = 1'b0;
      case (r_state)
         SCAN: begin
            if (!w_settle_done) begin
               w_settle_inc = 1'b1;
            end else if (w_one_low) begin
               w_capture   = 1'b1;
               w_db_clr    = 1'b1;
               w_state_nxt = DEBOUNCE;
            end else begin
               w_col_adv    = 1'b1;
               w_settle_clr = 1'b1;
            end
         end
         DEBOUNCE: begin
            if (w_rs != r_pat) begin
               w_settle_clr = 1'b1;
               w_state_nxt  = SCAN;
            end else if (w_db_full) begin
               w_emit      = 1'b1;
               w_held_set  = 1'b1;
               w_state_nxt = HELD;
            end else begin
               w_db_inc = 1'b1;
            end
         end
         HELD: begin
            if (w_rs_idle) begin
               w_db_clr    = 1'b1;
               w_state_nxt = RELEASE;
            end
`ifdef KEYPAD_AUTOREPEAT_EN
            else if (w_rep_hit) begin
               w_emit = 1'b1;
            end
`endif
         end
         RELEASE: begin
            if (!w_rs_idle) begin
               w_state_nxt = HELD;
            end else if (w_db_full) begin
               w_held_clr   = 1'b1;
               w_col_adv    = 1'b1;
               w_settle_clr = 1'b1;
               w_state_nxt  = SCAN;
            end else begin
               w_db_inc = 1'b1;
            end
         end
         default: w_state_nxt = SCAN;
      endcase
   end

   // Scan position, settle/debounce counters and captured key.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_settle <= '0;
         r_db     <= '0;
         r_col    <= '0;
         r_col_o  <= ~COLS'(1);
         r_row    <= '0;
         r_pat    <= '1;
         r_held   <= 1'b0;
      end else begin
         if (w_settle_clr)      r_settle <= '0;
         else if (w_settle_inc) r_settle <= r_settle + SET_W'(1);
         if (w_db_clr)          r_db <= '0;
         else if (w_db_inc)     r_db <= r_db + DB_N'(1);
         if (w_col_adv) begin
            r_col   <= w_col_nxt;
            r_col_o <= ~(COLS'(1) << w_col_nxt);
         end
         if (w_capture) begin
            r_row <= w_row_idx;
            r_pat <= w_rs;
         end
         if (w_held_set)        r_held <= 1'b1;
         else if (w_held_clr)   r_held <= 1'b0;
      end
   end

   // One-entry event register; a blocked emit is dropped and flagged.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_code  <= '0;
         r_valid <= 1'b0;
         r_ovr   <= 1'b0;
      end else begin
         r_ovr <= 1'b0;
         if (w_emit && (!r_valid || key_ready)) begin
            r_code  <= w_code;
            r_valid <= 1'b1;
         end else begin
            if (w_emit)    r_ovr   <= 1'b1;
            if (key_ready) r_valid <= 1'b0;
         end
      end
   end

`ifdef KEYPAD_AUTOREPEAT_EN
   assign w_rep_hit = (r_rep == (r_rep_first ? REP_W'(REPEAT_DLY - 1) : REP_W'(REPEAT_PER - 1)));

   // Repeat timer restarts on every entry into HELD.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_rep       <= '0;
         r_rep_first <= 1'b1;
      end else if (w_state_nxt == HELD && r_state != HELD) begin
         r_rep       <= '0;
         r_rep_first <= 1'b1;
      end else if (r_state == HELD && !w_rs_idle) begin
         if (w_rep_hit) begin
            r_rep       <= '0;
            r_rep_first <= 1'b0;
         end else begin
            r_rep <= r_rep + REP_W'(1);
         end
      end
   end
`endif

   assign col_o     = r_col_o;
   assign key_code  = r_code;
   assign key_valid = r_valid;
   assign key_held  = r_held;
   assign overrun   = r_ovr;

endmodule

// File: tb/tb_mod_keypad_scan_ctrl.sv
// Directed bench for mod_keypad_scan_ctrl with a 4x4 switch-matrix model.
module tb_mod_keypad_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic [3:0]  col_o;
   logic [3:0]  row_i;
   logic [3:0]  key_code;
   logic        key_valid;
   logic        key_ready = 1'b1;
   logic        key_held;
   logic        overrun;
   logic [15:0] keys = '0;

   int n_chk = 0;
   int n_err = 0;
   int ev_cnt = 0;
   int ev0;

   always #5 clk = ~clk;

   mod_keypad_scan_ctrl #(
      .ROWS(4), .COLS(4), .SETTLE_CYC(4), .DB_N(4), .REPEAT_DLY(20), .REPEAT_PER(8)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .col_o     (col_o),
      .row_i     (row_i),
      .key_code  (key_code),
      .key_valid (key_valid),
      .key_ready (key_ready),
      .key_held  (key_held),
      .overrun   (overrun)
   );

   // Pressed key (r,c) pulls row r low while column c is driven low.
   always_comb begin
      row_i = '1;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            if (keys[r*4+c] && !col_o[c]) row_i[r] = 1'b0;
   end

   always @(negedge clk) if (key_valid && key_ready) ev_cnt++;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      keys = '0;
      key_ready = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
   endtask

   // sel: 0 key_valid, 1 key_held, 2 overrun, other col_o
   task automatic wait_for(input int sel, input logic [3:0] val, input string tag);
      int   n;
      logic hit;
      n = 0;
      hit = 1'b0;
      while (!hit && n < 300) begin
         @(negedge clk);
         n++;
         case (sel)
            0:       hit = (key_valid === val[0]);
            1:       hit = (key_held === val[0]);
            2:       hit = (overrun === val[0]);
            default: hit = (col_o === val);
         endcase
      end
      chk({tag, "_reached"}, 32'(hit), 32'd1);
   endtask

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      chk("rst_col", 32'(col_o), 32'hE);
      chk("rst_valid", 32'(key_valid), 32'd0);
      chk("rst_held", 32'(key_held), 32'd0);
      chk("rst_code", 32'(key_code), 32'd0);
      chk("rst_ovr", 32'(overrun), 32'd0);

      // 1: clean press of key 9 (row 2, col 1)
      do_reset();
      wait_for(3, 4'b1101, "t1_col1");
      keys[9] = 1'b1;
      ev0 = ev_cnt;
      repeat (19) @(negedge clk);
      chk("t1_valid_early", 32'(key_valid), 32'd0);
      @(negedge clk);
      chk("t1_valid", 32'(key_valid), 32'd1);
      chk("t1_code", 32'(key_code), 32'd9);
      chk("t1_held_on", 32'(key_held), 32'd1);
      @(negedge clk);
      chk("t1_valid_drop", 32'(key_valid), 32'd0);
      repeat (20) @(negedge clk);
      chk("t1_one_event", 32'(ev_cnt - ev0), 32'd1);
      keys[9] = 1'b0;
      repeat (18) @(negedge clk);
      chk("t1_held_late", 32'(key_held), 32'd1);
      @(negedge clk);
      chk("t1_held_off", 32'(key_held), 32'd0);
      chk("t1_col_adv", 32'(col_o), 32'hB);

      // 2: bouncing key 3 (row 0, col 3)
      do_reset();
      wait_for(3, 4'b0111, "t2_col3");
      ev0 = ev_cnt;
      for (int i = 0; i < 8; i++) begin
         keys[3] = (i % 2 == 0);
         repeat (5) @(negedge clk);
      end
      chk("t2_no_bounce_ev", 32'(ev_cnt - ev0), 32'd0);
      chk("t2_no_held", 32'(key_held), 32'd0);
      keys[3] = 1'b1;
      wait_for(0, 4'd1, "t2_valid");
      chk("t2_code", 32'(key_code), 32'd3);
      repeat (40) @(negedge clk);
      chk("t2_single_ev", 32'(ev_cnt - ev0), 32'd1);
      keys[3] = 1'b0;
      wait_for(1, 4'd0, "t2_release");

      // 3: ghost pattern, rows 1 and 3 on column 2
      do_reset();
      keys[6] = 1'b1;
      keys[14] = 1'b1;
      ev0 = ev_cnt;
      repeat (3) @(negedge clk);
      chk("t3_col0", 32'(col_o), 32'hE);
      @(negedge clk);
      chk("t3_col1", 32'(col_o), 32'hD);
      repeat (4) @(negedge clk);
      chk("t3_col2", 32'(col_o), 32'hB);
      repeat (4) @(negedge clk);
      chk("t3_col3", 32'(col_o), 32'h7);
      repeat (4) @(negedge clk);
      chk("t3_wrap", 32'(col_o), 32'hE);
      repeat (40) @(negedge clk);
      chk("t3_no_ev", 32'(ev_cnt - ev0), 32'd0);
      chk("t3_no_held", 32'(key_held), 32'd0);

      // 4: consumer stalled, second key dropped with overrun
      do_reset();
      key_ready = 1'b0;
      keys[5] = 1'b1;
      wait_for(0, 4'd1, "t4_valid5");
      chk("t4_code5", 32'(key_code), 32'd5);
      keys[5] = 1'b0;
      wait_for(1, 4'd0, "t4_rel5");
      keys[6] = 1'b1;
      wait_for(2, 4'd1, "t4_ovr");
      chk("t4_code_kept", 32'(key_code), 32'd5);
      chk("t4_valid_kept", 32'(key_valid), 32'd1);
      @(negedge clk);
      chk("t4_ovr_pulse", 32'(overrun), 32'd0);
      key_ready = 1'b1;
      @(negedge clk);
      chk("t4_accept", 32'(key_valid), 32'd0);
      keys[6] = 1'b0;
      wait_for(1, 4'd0, "t4_rel6");

      // 5: reset while held with an event pending
      do_reset();
      key_ready = 1'b0;
      keys[0] = 1'b1;
      wait_for(1, 4'd1, "t5_held");
      chk("t5_pending", 32'(key_valid), 32'd1);
      @(negedge clk);
      rst = 1'b0;
      #1;
      chk("t5_col", 32'(col_o), 32'hE);
      chk("t5_valid", 32'(key_valid), 32'd0);
      chk("t5_held_clr", 32'(key_held), 32'd0);
      keys[0] = 1'b0;
      key_ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      rst = 1'b1;
      repeat (4) @(negedge clk);
      chk("t5_rescan", 32'(col_o), 32'hD);

      // 6: long hold of key 0; repeats only with auto-repeat built in
      do_reset();
      keys[0] = 1'b1;
      wait_for(0, 4'd1, "t6_valid");
      chk("t6_code", 32'(key_code), 32'd0);
      @(negedge clk);
      ev0 = ev_cnt;
      repeat (58) @(negedge clk);
`ifdef KEYPAD_AUTOREPEAT_EN
      chk("t6_repeats", 32'(ev_cnt - ev0), 32'd5);
`else
      chk("t6_no_repeat", 32'(ev_cnt - ev0), 32'd0);
`endif
      keys[0] = 1'b0;
      wait_for(1, 4'd0, "t6_release");

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end

endmodule

// File: doc/mod_keypad_scan_ctrl.md
Name: mod_keypad_scan_ctrl

Overview:
Scan controller for the calculator's matrix keypad. It drives one column low at a time, samples the synchronized row lines, and debounces the press and release of a single key with an internal stable-count counter. It emits a key code through a one-entry valid/ready output register to the calculator input FSM. It replaces one debouncer per key with one sequenced debounce datapath shared by all keys.

Parameters:
ROWS, 4, number of row inputs.
COLS, 4, number of column outputs.
SETTLE_CYC, 8, cycles each column is driven before its rows are sampled; must be >= 3 to cover synchronizer latency.
DB_N, 15, debounce counter width; a level is stable when the counter is all ones (2^DB_N - 1 cycles).
REPEAT_DLY, 2^22, auto-repeat first delay in cycles (used only with the macro).
REPEAT_PER, 2^20, auto-repeat period in cycles (used only with the macro).

Ports:
clk  in  1  system clock.
rst  in  1  reset, asynchronous assert, active-low (0 = reset).
col_o  out  COLS  column drive, active-low, exactly one bit low at any time.
row_i  in  ROWS  raw row lines, active-low (0 = pressed), asynchronous to clk.
key_code  out  $clog2(ROWS*COLS)  key index = row*COLS + col; stable while key_valid = 1.
key_valid  out  1  key event pending.
key_ready  in  1  consumer accepts; handshake completes on the clk edge where key_valid & key_ready.
key_held  out  1  high while the debounced key is down.
overrun  out  1  one-cycle pulse when a key event is dropped because the previous event is still pending.

Behaviour:
- row_i passes through a 2-FF synchronizer, reset to all ones. All later logic uses the synchronized value rs.
- Reset values: col index = 0, so col_o = ~1. key_code = 0, key_valid = 0, key_held = 0, overrun = 0, counters = 0, state = SCAN.
- SCAN state:
  - The settle counter runs from 0 to SETTLE_CYC-1, then rs is evaluated.
  - Exactly one bit low: capture the row index and pattern, clear the debounce counter, go to DEBOUNCE. The column stays frozen.
  - All ones, or more than one bit low (ghosting): advance the column. The column wraps from COLS-1 to 0. Clear the settle counter.
- DEBOUNCE state:
  - The counter increments each cycle while rs equals the captured pattern.
  - Any mismatch: go to SCAN, column unchanged, settle counter cleared.
  - Counter all ones and rs still matches: go to HELD and emit the key event on the same edge.
- Key emit:
  - If key_valid = 0 or key_ready = 1 on that edge: key_code <= row*COLS+col, key_valid <= 1.
  - Otherwise: the event is dropped, overrun pulses for 1 cycle, and the pending code is kept.
- key_valid clears on the edge with key_ready = 1, unless a new emit happens on that same edge. A simultaneous accept and emit loads the new code with key_valid staying 1.
- HELD state: key_held = 1. When rs becomes all ones, clear the counter and go to RELEASE.
- RELEASE state:
  - The counter increments while rs is all ones; any low bit returns to HELD.
  - Counter all ones: key_held <= 0, advance the column, go to SCAN.
- Only one key is tracked. Other keys are ignored until release completes.
- Reset asserted mid-operation returns everything to reset values immediately. A pending key is lost.
- Counter arithmetic is unsigned and saturates only through state exit; there is no wrap inside DEBOUNCE or RELEASE.

Optional Feature:
KEYPAD_AUTOREPEAT_EN
- Defined: in HELD, a repeat counter emits the same key event after REPEAT_DLY cycles, then every REPEAT_PER cycles. The same emit and overrun rules apply. The counter resets on entry to HELD.
- Undefined: exactly one event per press. The REPEAT_* parameters are unused and the repeat counter is not synthesized.

Decomposition:
- Package keypad_pkg holds:
  - the state enum SCAN, DEBOUNCE, HELD, RELEASE, encoded in 2 bits;
  - the localparam function for code width;
  - the constant KEY_NONE = all ones.
- Sub-module mod_sync2: a parameterized-width 2-FF synchronizer with active-low asynchronous reset and reset value as a parameter. It is reused by other calculator inputs.

Test Plan:
All scenarios use ROWS=4, COLS=4, SETTLE_CYC=4, DB_N=4, key_ready tied to 1 unless stated.
1. Press row 2 while col_o = 4'b1101 (col 1), held clean -> key_valid pulses once with key_code = 9 exactly 4+15 cycles after the sample point. key_held stays 1 until 15 cycles after release.
2. Bounce row 0 on col 3 (toggle every 5 cycles for 40 cycles, then stable) -> no event during bounce; a single key_code = 3 after the last stable 15 cycles.
3. Rows 1 and 3 both low on the same column -> no event, scanning continues, col_o cycles 1110, 1101, 1011, 0111, 1110.
4. key_ready = 0; press key 5, release, press key 6 -> key_code stays 5, overrun pulses 1 cycle at the second emit. key_ready = 1 then accepts 5 and key_valid drops.
5. Assert rst = 0 during HELD -> on the next sample, col_o = 1110, key_valid = 0, key_held = 0, and scanning restarts after rst = 1.
6. With KEYPAD_AUTOREPEAT_EN, REPEAT_DLY=20, REPEAT_PER=8, hold key 0 for 60 cycles after the emit -> repeat events at +20, +28, +36, +44, +52.
